fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the word FIFO. Pops one word at a time from the FIFO read port and serializes it onto a UART line: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
- Contains its own 16x-oversampling baud divider.
- Sits between a FIFO's empty/rd/r_data outputs and the chip-level tx pin.

Parameters:
- DATA_WIDTH, 8: bits per word; must match the FIFO word width.
- SB_TICK, 16: oversample ticks in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- DVSR, 326: clock cycles per oversample tick (clk / (16 * baud)).
- DVSR_WIDTH, 11: width of the divider counter; requires DVSR <= 2**DVSR_WIDTH.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- tx_en, input, 1: permits starting a new frame.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_r_data, input, DATA_WIDTH: FIFO head word, valid whenever fifo_empty=0.
- fifo_rd, output, 1: one-cycle pop strobe to the FIFO.
- tx, output, 1: serial line; idles high.
- tx_busy, output, 1: high while a frame is in progress.
- tx_done, output, 1: one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high:
  - state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done=0.
  - Divider, tick count and bit count are 0; shift register is 0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to tx.
- Divider:
  - Counts 0..DVSR-1 and wraps.
  - Tick is high when count==DVSR-1.
  - Divider clears to 0 on every frame start, so every bit lasts exactly 16*DVSR clocks and the stop bit lasts SB_TICK*DVSR clocks.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a clock where tx_en=1 and fifo_empty=0: shift register <= fifo_r_data, fifo_rd=1 for exactly that cycle, move to START.
  - From the next cycle: tx=0, tx_busy=1.
- START:
  - Count ticks in s (0..15). On the tick with s==15, clear s, clear n, move to DATA.
- DATA:
  - tx = shift register bit 0.
  - On the tick with s==15: shift right by one, clear s. If n==DATA_WIDTH-1 move to STOP, else n++.
- STOP:
  - tx=1.
  - On the tick with s==SB_TICK-1: tx_done=1 for that cycle.
  - If tx_en=1 and fifo_empty=0 on that same cycle, load and pop as in IDLE and go directly to START (zero-gap back-to-back). Otherwise go to IDLE with tx_busy=0.
- fifo_rd:
  - Never asserted when fifo_empty=1.
  - Never asserted more than once per frame.
  - Never asserted on consecutive cycles.
- tx_en deasserted mid-frame: the current frame completes unchanged; no new pop occurs.
- fifo_r_data changes mid-frame: ignored, because the word is latched at pop.
- Reset mid-frame:
  - tx returns high immediately (asynchronously) and the FSM goes to IDLE.
  - The popped word is discarded; no retransmit.
  - After release, a new frame starts only via the IDLE rule.
- Frame length: (1 + DATA_WIDTH) * 16 * DVSR + SB_TICK * DVSR clocks, measured from the first tx=0 cycle to the tx_done cycle inclusive.

Test Plan:
Bench settings: DVSR=4, DATA_WIDTH=8, SB_TICK=16, so one bit = 64 clocks and one frame = 640 clocks.
1. Reset asserted with FIFO non-empty and tx_en=1 -> tx=1, fifo_rd=0, tx_busy=0 throughout reset; first pop occurs on the first edge after release.
2. FIFO holds 0xA5, tx_en=1 ->
   - fifo_rd high for exactly 1 cycle.
   - tx: start bit 0 for 64 clocks, then 1,0,1,0,0,1,0,1 at 64 clocks each, then stop 1 for 64 clocks.
   - tx_done pulses at clock 640.
   - tx_busy falls after the tx_done cycle.
3. FIFO holds 0x00 then 0xFF ->
   - Second pop coincides with the first frame's tx_done.
   - Second start bit begins with no idle gap; no extra high cycle.
   - Exactly 2 fifo_rd pulses in total.
4. tx_en=0 with FIFO non-empty -> no fifo_rd, tx stays 1 for 2000 clocks. Raise tx_en, then drop it 100 clocks into the frame -> the frame completes and no second pop occurs.
5. Reset asserted at clock 300 of a frame (in DATA) -> tx=1 in the same cycle, tx_busy=0. After release with the next word 0x3C available, a new full frame of 0x3C is sent.
6. SB_TICK=32 with 0x81 -> stop bit high for 128 clocks; tx_done at clock 704.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a word FIFO: pops one word per frame and sends
// start bit, DATA_WIDTH data bits LSB first, then the stop bit(s).
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 326,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [DVSR_WIDTH-1:0]   div_q, div_d;
  logic [S_W-1:0]          s_q, s_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tick;
  logic                    can_load;
  logic                    load;

  assign tick     = (div_q == DVSR_WIDTH'(DVSR - 1));
  // Reset gates the pop so a held-off word is never consumed while in reset.
  assign can_load = tx_en && !fifo_empty && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    tx_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_load) load = 1'b1;
      end
      START: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            shreg_d = shreg_q >> 1;
            if (n_q == N_W'(DATA_WIDTH - 1)) state_d = STOP;
            else                             n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            tx_done = 1'b1;
            s_d     = '0;
            // A ready word on the final stop tick chains straight into the next frame.
            if (can_load) load = 1'b1;
            else          state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shreg_d = fifo_r_data;
      div_d   = '0;
      s_d     = '0;
      n_d     = '0;
      state_d = START;
    end
  end

  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shreg_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign fifo_rd = load;
  assign tx_busy = (state_q != IDLE);

endmodule
